// File: rtl/branch_redirect_unit.sv
// Two-lane branch redirect unit: each lane turns a taken branch into a fetch redirect handshake
// followed by a fixed flush window. Optional statistics counters: define BRANCH_REDIRECT_STATS_EN.

module branch_redirect_lane #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort_i,
    input  logic            br_valid_i,
    input  logic            taken_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            ready_i,
    output logic            redir_valid_o,
    output logic [XLEN-1:0] redir_pc_o,
    output logic            busy_o
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]     stat_taken_o,
    output logic [31:0]     stat_redir_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, busy_q;
    logic            hs_s;
    logic            taken_s;

    assign taken_s = br_valid_i & taken_i;

    // Next-state: abort wins over everything; captures happen only from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        hs_s    = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (taken_s) begin
                        state_d = ST_REDIR;
                        pc_d    = {target_i[XLEN-1:1], 1'b0};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    if (ready_i) begin
                        hs_s = 1'b1;
                        if (FLUSH_LOAD == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_LOAD;
                        end
                    end else begin
                        state_d = ST_REDIR;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State, captured PC and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == ST_REDIR);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign redir_valid_o = valid_q;
    assign redir_pc_o    = pc_q;
    assign busy_o        = busy_q;

`ifdef BRANCH_REDIRECT_STATS_EN
    logic [31:0] stat_taken_q, stat_redir_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken_q <= 32'd0;
            stat_redir_q <= 32'd0;
        end else begin
            if (taken_s) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end else begin
                stat_taken_q <= stat_taken_q;
            end
            if (hs_s) begin
                stat_redir_q <= stat_redir_q + 32'd1;
            end else begin
                stat_redir_q <= stat_redir_q;
            end
        end
    end

    assign stat_taken_o = stat_taken_q;
    assign stat_redir_o = stat_redir_q;
`endif

endmodule

module branch_redirect_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            br_validA,
    input  logic            branch_takenA,
    input  logic [XLEN-1:0] targetA,
    input  logic            br_validB,
    input  logic            branch_takenB,
    input  logic [XLEN-1:0] targetB,
    input  logic            redir_readyA,
    input  logic            redir_readyB,
    output logic            redir_validA,
    output logic [XLEN-1:0] redir_pcA,
    output logic            redir_validB,
    output logic [XLEN-1:0] redir_pcB,
    output logic            flushA,
    output logic            flushB,
    output logic            busyA,
    output logic            busyB
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]     stat_takenA,
    output logic [31:0]     stat_takenB,
    output logic [31:0]     stat_redirA,
    output logic [31:0]     stat_redirB
`endif
);

    logic busy_a_s, busy_b_s;
    logic br_valid_b_s;

    // In unified mode lane B sees no branches and is held in IDLE.
    assign br_valid_b_s = br_validB & ~mode;

    branch_redirect_lane #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_lane_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort_i       (1'b0),
        .br_valid_i    (br_validA),
        .taken_i       (branch_takenA),
        .target_i      (targetA),
        .ready_i       (redir_readyA),
        .redir_valid_o (redir_validA),
        .redir_pc_o    (redir_pcA),
        .busy_o        (busy_a_s)
`ifdef BRANCH_REDIRECT_STATS_EN
        ,
        .stat_taken_o  (stat_takenA),
        .stat_redir_o  (stat_redirA)
`endif
    );

    branch_redirect_lane #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_lane_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort_i       (mode),
        .br_valid_i    (br_valid_b_s),
        .taken_i       (branch_takenB),
        .target_i      (targetB),
        .ready_i       (redir_readyB),
        .redir_valid_o (redir_validB),
        .redir_pc_o    (redir_pcB),
        .busy_o        (busy_b_s)
`ifdef BRANCH_REDIRECT_STATS_EN
        ,
        .stat_taken_o  (stat_takenB),
        .stat_redir_o  (stat_redirB)
`endif
    );

    assign busyA  = busy_a_s;
    assign flushA = busy_a_s;
    assign busyB  = busy_b_s;
    assign flushB = busy_b_s;

endmodule
